// File: rtl/pfifo.sv
// +----------------------------------------------------------------------------+
// | Module   : pfifo                                                           |
// | Desc     : Parametrised synchronous FIFO with almost-full/empty thresholds,|
// |            occupancy count, read-valid strobe and optional sticky error    |
// |            flags enabled by the PFIFO_ERR_FLAGS_EN macro.                  |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module pfifo #(
   parameter int WIDTH  = 4,
   parameter int DEPTH  = 16,
   parameter int AF_LVL = DEPTH - 2,
   parameter int AE_LVL = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [WIDTH-1:0]           in,
   input  logic                       re,
   output logic [WIDTH-1:0]           out,
   output logic                       vld,
   output logic                       f,
   output logic                       e,
   output logic                       af,
   output logic                       ae,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       ovf,
   output logic                       udf
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);
   localparam logic [AW:0] c_af    = (AW+1)'(AF_LVL);
   localparam logic [AW:0] c_ae    = (AW+1)'(AE_LVL);
   localparam logic [AW:0] c_one   = (AW+1)'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wp;
   logic [AW-1:0]    r_rp;
   logic [AW:0]      r_count;
   logic [WIDTH-1:0] r_out;
   logic             r_vld;
   logic             w_rd_acc;
   logic             w_wr_acc;

   // Flags decode the registered count so they track it with no extra latency.
   assign e  = (r_count == '0);
   assign f  = (r_count == c_depth);
   assign af = (r_count >= c_af);
   assign ae = (r_count <= c_ae);

   // A full FIFO can still take a write when a read frees a slot on the same edge.
   assign w_rd_acc = re && !e;
   assign w_wr_acc = we && (!f || w_rd_acc);

   assign out   = r_out;
   assign vld   = r_vld;
   assign count = r_count;

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wp] <= in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_out   <= '0;
         r_vld   <= 1'b0;
      end else begin
         r_vld <= w_rd_acc;
         if (w_wr_acc) begin
            r_wp <= r_wp + AW'(1);
         end
         if (w_rd_acc) begin
            r_out <= r_mem[r_rp];
            r_rp  <= r_rp + AW'(1);
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + c_one;
            2'b01:   r_count <= r_count - c_one;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef PFIFO_ERR_FLAGS_EN
   logic r_ovf;
   logic r_udf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (we && !w_wr_acc) begin
            r_ovf <= 1'b1;
         end
         if (re && e) begin
            r_udf <= 1'b1;
         end
      end
   end

   assign ovf = r_ovf;
   assign udf = r_udf;
`else
   assign ovf = 1'b0;
   assign udf = 1'b0;
`endif

endmodule

`default_nettype wire
